// File: rtl/alu_defs.sv
// Shared ALU definitions: opcode constants, default datapath width and the
// state encoding used by the multi-cycle divider.
package alu_defs;

   localparam int ALU_WIDTH = 32;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_DIVU = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/divu_sequencer_if.sv
// Request/result bundle between the ID/EX stage (master) and the divider (slave).
interface divu_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       signal_in;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             flush;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, signal_in, dividend, divisor, flush,
      input  busy, stall, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signal_in, dividend, divisor, flush,
      output busy, stall, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divu_step.sv
// One restoring shift-subtract iteration: shift {rem,quo} left by one, try to
// subtract the divisor at WIDTH+1 bits, keep the difference if non-negative.
module divu_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;

   // Trial subtraction and restore decision.
   always_comb begin
      // NOTE: every output gets a value on every path; a missed branch here
      // would infer a latch instead of combinational logic.
      rem_sh   = {rem, quo[WIDTH-1]};
      trial    = rem_sh - {1'b0, divisor};
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/divu_sequencer.sv
// Multi-cycle unsigned divider controller for DIVU. Runs WIDTH restoring
// steps, stalls the pipeline while running and holds quotient/remainder for
// HI/LO writeback until the next completion.
module divu_sequencer
   import alu_defs::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input logic              clk,
   input logic              reset,
   divu_sequencer_if.slave  bus
);

   div_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_n;
   logic [WIDTH-1:0] quo_n;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;
   logic             is_divu;
   logic             accept;

   assign is_divu = bus.start && (bus.signal_in == ALU_DIVU);
   assign accept  = is_divu && (state == ST_IDLE || state == ST_DONE) && !bus.flush;

   divu_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dsr_q),
      .rem_next (rem_n),
      .quo_next (quo_n)
   );

   // Control FSM, iteration counter, working registers and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: state is updated with non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state       <= ST_IDLE;
         cnt         <= '0;
         dsr_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else if (bus.flush) begin
         // Abort wins over accept and completion; results are left untouched.
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               state <= ST_IDLE;
               if (accept) begin
                  if (bus.divisor == '0) begin
                     state       <= ST_DONE;
                     quotient_q  <= '1;
                     remainder_q <= bus.dividend;
                     dbz_q       <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                     dsr_q <= bus.divisor;
                     quo_q <= bus.dividend;
                     rem_q <= '0;
                     cnt   <= '0;
                  end
               end
            end
            ST_RUN: begin
               rem_q <= rem_n;
               quo_q <= quo_n;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state       <= ST_DONE;
                  quotient_q  <= quo_n;
                  remainder_q <= rem_n;
                  dbz_q       <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy        = (state == ST_RUN);
   assign bus.done        = (state == ST_DONE);
   assign bus.stall       = (state == ST_RUN) || (is_divu && !bus.flush);
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu_sequencer.sv
// Scoreboard bench for divu_sequencer: the driver pushes the expected result
// and completion cycle of each accepted divide; the monitor pops on done.
module tb_divu_sequencer;
   import alu_defs::*;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   last_acc;

   exp_t         sb[$];
   exp_t         mon_e;
   logic [W-1:0] hq, hr;
   logic         hd;

   divu_sequencer_if #(.WIDTH(W)) bus ();

   divu_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain unsigned arithmetic, divide by zero gives all-ones/dividend.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
      exp_t e;
      if (b == 0) begin
         e.q = '1; e.r = a; e.dbz = 1'b1; e.cyc = c;
      end else begin
         e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.cyc = c + W;
      end
      return e;
   endfunction

   // Present a request in the current cycle and check the combinational stall.
   task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start     = 1'b1;
      bus.signal_in = op;
      bus.dividend  = a;
      bus.divisor   = b;
      #1;
      check("stall_req", {63'd0, bus.stall}, {63'd0, op == ALU_DIVU});
   endtask

   // Drive a divide, let the next edge accept it and record the expectation.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      drive(ALU_DIVU, a, b);
      @(posedge clk); #1;
      last_acc = cyc;
      sb.push_back(model(a, b, cyc));
      bus.start     = 1'b0;
      bus.signal_in = 4'b0000;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk); #1;
      end
      check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: compare on every done pulse and check results hold otherwise.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check("quotient", 64'(bus.quotient), 64'(mon_e.q));
               check("remainder", 64'(bus.remainder), 64'(mon_e.r));
               check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, mon_e.dbz});
               check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
               hq = mon_e.q; hr = mon_e.r; hd = mon_e.dbz;
            end
         end
         check("hold_q", 64'(bus.quotient), 64'(hq));
         check("hold_r", 64'(bus.remainder), 64'(hr));
         check("hold_dbz", {63'd0, bus.div_by_zero}, {63'd0, hd});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] a, b;
      hq = '0; hr = '0; hd = 1'b0;
      reset = 1'b0;
      bus.start = 1'b0; bus.signal_in = 4'b0000;
      bus.dividend = '0; bus.divisor = '0; bus.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_q", 64'(bus.quotient), 64'd0);
      check("rst_r", 64'(bus.remainder), 64'd0);
      check("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Basic 100/7 with busy/stall timing through RUN and the DONE cycle.
      issue(32'd100, 32'd7);
      for (int k = 0; k < W; k++) begin
         check("run_busy_stall", {62'd0, bus.busy, bus.stall}, 64'd3);
         @(posedge clk); #1;
      end
      check("done_cycle_busy_stall", {62'd0, bus.busy, bus.stall}, 64'd0);
      check("done_pulse", {63'd0, bus.done}, 64'd1);
      @(posedge clk); #1;
      check("basic_q", 64'(bus.quotient), 64'd14);
      check("basic_r", 64'(bus.remainder), 64'd2);
      check("done_one_cycle", {63'd0, bus.done}, 64'd0);

      // Full-range operands.
      issue(32'hFFFF_FFFF, 32'd1);
      wait_drain();
      issue(32'h1234_5678, 32'hFFFF_FFFF);
      wait_drain();
      check("fr_q", 64'(bus.quotient), 64'd0);

      // Divide by zero, then a normal divide clears the flag.
      issue(32'd5, 32'd0);
      check("dbz_no_busy", {63'd0, bus.busy}, 64'd0);
      wait_drain();
      check("dbz_flag", {63'd0, bus.div_by_zero}, 64'd1);
      issue(32'd9, 32'd3);
      wait_drain();
      check("dbz_cleared_q", {31'd0, bus.quotient, bus.div_by_zero}, 64'd6);

      // Non-divide opcode is ignored.
      drive(ALU_ADD, 32'd8, 32'd2);
      @(posedge clk); #1;
      check("add_ignored", {62'd0, bus.busy, bus.done}, 64'd0);
      bus.start = 1'b0;

      // DIVU while running is ignored.
      issue(32'd100, 32'd7);
      repeat (3) begin
         bus.start = 1'b1; bus.signal_in = ALU_DIVU;
         bus.dividend = 32'd1000; bus.divisor = 32'd3;
         #1;
         check("run_req_stall", {62'd0, bus.busy, bus.stall}, 64'd3);
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      wait_drain();

      // Flush at iteration 10: no done, results held.
      issue(32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      void'(sb.pop_back());
      check("flush_idle", {63'd0, bus.busy}, 64'd0);
      repeat (40) @(posedge clk);
      #1;
      check("flush_hold_q", 64'(bus.quotient), 64'd14);

      // Reset at iteration 10: outputs clear at once, no done afterwards.
      issue(32'd1000, 32'd3);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      hq = '0; hr = '0; hd = 1'b0;
      #1;
      check("midrst_q", 64'(bus.quotient), 64'd0);
      check("midrst_r", 64'(bus.remainder), 64'd0);
      check("midrst_busy", {62'd0, bus.busy, bus.done}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("midrst_idle", {63'd0, bus.busy}, 64'd0);

      // Back-to-back accept in the DONE cycle.
      issue(32'd100, 32'd7);
      repeat (W) @(posedge clk);
      #1;
      check("b2b_in_done", {63'd0, bus.done}, 64'd1);
      issue(32'd50, 32'd5);
      check("b2b_running", {63'd0, bus.busy}, 64'd1);
      wait_drain();
      check("b2b_q", 64'(bus.quotient), 64'd10);

      // Randomized operands against the arithmetic model.
      for (int n = 0; n < 25; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 15));
            2:       b = $urandom;
            default: b = (a >> $urandom_range(0, 31)) | 32'd1;
         endcase
         issue(a, b);
         wait_drain();
      end

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/divu_sequencer.md
Name: divu_sequencer

Overview:
Multi-cycle controller that executes the ALU DIVU operation (opcode 4'b0100) as a restoring shift-subtract divider over WIDTH cycles. It sits beside the single-cycle ALU/shifter in EX. It accepts a divide request from the ID/EX stage and stalls the pipeline while it runs. When finished, it presents the quotient and remainder for the HI/LO writeback.

Parameters:
WIDTH, 32, operand/result width in bits
CNT_W, 5, iteration counter width; must equal clog2(WIDTH)

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request valid from ID/EX
signal_in  in  4  ALU control code; a request is a divide only when equal to DIVU (4'b0100)
dividend  in  WIDTH  unsigned dividend, sampled on accept
divisor  in  WIDTH  unsigned divisor, sampled on accept
flush  in  1  pipeline flush; aborts any operation in progress
busy  out  1  high while in RUN
stall  out  1  pipeline hold request
done  out  1  one-cycle pulse when results become valid
quotient  out  WIDTH  result, held until the next completion
remainder  out  WIDTH  result, held until the next completion
div_by_zero  out  1  set with done when divisor was 0; held with results

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0. busy, done, div_by_zero, quotient and remainder are all 0.
- States: IDLE, RUN, DONE.
- accept = start && (signal_in==DIVU) && (state==IDLE || state==DONE) && !flush.
- IDLE/DONE -> RUN on accept with a nonzero divisor. On that edge:
  - latch divisor;
  - load the dividend into the shift register;
  - clear the partial remainder;
  - counter=0.
- IDLE/DONE -> DONE on accept with divisor==0. Results: quotient=all-ones, remainder=dividend, div_by_zero=1. Latency is 1 cycle.
- RUN: each cycle performs one restoring step.
  - Shift {rem,quo} left by 1.
  - trial = rem_shifted − divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: rem=trial and quo LSB=1; otherwise rem is unchanged and quo LSB=0.
  - counter increments; after step WIDTH−1 (counter==WIDTH−1) -> DONE.
- RUN lasts exactly WIDTH cycles. done is asserted in cycle WIDTH+1 after the accept edge.
- DONE: done=1 for exactly that cycle, quotient/remainder outputs valid. Then -> IDLE, unless a new accept occurs in the same cycle.
- A back-to-back accept in the DONE cycle is legal: done still pulses, and the outputs stay valid that cycle.
- quotient, remainder and div_by_zero update only on entry to DONE and hold otherwise. Any nonzero-divisor completion clears div_by_zero.
- busy = (state==RUN).
- stall = busy || (start && signal_in==DIVU && !flush). stall is combinational, so the issuing instruction is held in its accept cycle. stall=0 in the DONE cycle, unless a new divide is accepted.
- start with any other signal_in: ignored in every state, stall=0.
- start while in RUN: ignored. The requester remains stalled by busy.
- flush in any state: next state IDLE and counter=0. Outputs are unchanged and done is not pulsed. flush has priority over accept and over completion in the same cycle.
- Reset mid-operation clears everything immediately; there is no partial result.
- Arithmetic is unsigned only, with no overflow case.

Decomposition:
- Shared package alu_defs:
  - ALU opcode constants (ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001, SLT 4'b0111, SLL 4'b0011, DIVU 4'b0100);
  - state encoding typedef for IDLE/RUN/DONE;
  - WIDTH default.
- One sub-module, divu_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor. Outputs: next rem, next quo.
  - Verified standalone against the equation above.
- Everything else (FSM, counter, registers, stall logic) lives in divu_sequencer.

Test Plan:
- Basic divide: accept 100 / 7 at cycle 0 -> busy cycles 1–32, done=1 at cycle 33, quotient=14, remainder=2, div_by_zero=0. stall=1 in cycles 0–32.
- Full-range divide: 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0. Then 0x12345678 / 0xFFFFFFFF -> quotient=0, remainder=0x12345678.
- Divide by zero: 5 / 0 -> done at cycle 1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, busy never asserted. A following 9 / 3 clears div_by_zero and gives quotient=3, remainder=0.
- Aborts:
  - reset=0 at RUN iteration 10 -> all outputs 0 immediately, IDLE after release, no done pulse.
  - flush at iteration 10 -> IDLE next cycle, previous results held, no done pulse.
- Back-to-back: new accept of 50 / 5 in the DONE cycle of 100 / 7 -> first done shows 14/2. Second done 33 cycles later shows 10/0.
- Ignored requests:
  - start with signal_in=ADD -> stall=0, state stays IDLE.
  - start with DIVU during RUN -> ignored, the running operation completes unaffected.
